// File: rtl/ram_sp_arbiter_pkg.sv
// ram_sp_arbiter_pkg: grant encoding, last-grant reset value and address-width helper
package ram_sp_arbiter_pkg;

    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;

    localparam gnt_e LAST_GNT_RST = GNT_RD;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_req_slot.sv
// ram_req_slot: one-entry request holding register; frees itself in the cycle it is issued
module ram_req_slot #(
    parameter int W = 8
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Valid,
    output logic         o_Ready,
    input  logic [W-1:0] i_Data,
    input  logic         i_Issue,
    output logic         o_Full,
    output logic [W-1:0] o_Data
);

    logic         full;
    logic [W-1:0] data;

    // gated by reset so the slot never looks ready while held in reset
    assign o_Ready = i_Rst_L & (~full | i_Issue);
    assign o_Full  = full;
    assign o_Data  = data;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            full <= 1'b0;
            data <= '0;
        end else if (i_Valid && o_Ready) begin
            full <= 1'b1;
            data <= i_Data;
        end else if (i_Issue) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: single-port RAM front end with write/read request slots and registered read response.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise writes always win.
module ram_sp_arbiter
    import ram_sp_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Wr_Valid,
    output logic             o_Wr_Ready,
    input  logic [AW-1:0]    i_Wr_Addr,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic             i_Rd_Valid,
    output logic             o_Rd_Ready,
    input  logic [AW-1:0]    i_Rd_Addr,
    output logic             o_Rsp_Valid,
    input  logic             i_Rsp_Ready,
    output logic [WIDTH-1:0] o_Rsp_Data,
    output logic             o_Mem_Wr_En,
    output logic [AW-1:0]    o_Mem_Addr,
    output logic [WIDTH-1:0] o_Mem_Wr_Data,
    input  logic [WIDTH-1:0] i_Mem_Rd_Data
);

    logic                  wr_full;
    logic                  rd_full;
    logic                  rd_elig;
    logic [AW+WIDTH-1:0]   wr_pl;
    logic [AW-1:0]         rd_pl;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    gnt_e                  gnt;
    gnt_e                  pick;

    ram_req_slot #(.W(AW + WIDTH)) u_wr_slot (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Valid (i_Wr_Valid),
        .o_Ready (o_Wr_Ready),
        .i_Data  ({i_Wr_Addr, i_Wr_Data}),
        .i_Issue (gnt == GNT_WR),
        .o_Full  (wr_full),
        .o_Data  (wr_pl)
    );

    ram_req_slot #(.W(AW)) u_rd_slot (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Valid (i_Rd_Valid),
        .o_Ready (o_Rd_Ready),
        .i_Data  (i_Rd_Addr),
        .i_Issue (gnt == GNT_RD),
        .o_Full  (rd_full),
        .o_Data  (rd_pl)
    );

    // a read may only issue if the response register will be free at the next edge
    assign rd_elig = rd_full & (~rsp_valid | i_Rsp_Ready);

`ifdef ARB_ROUND_ROBIN_EN
    gnt_e last_gnt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            last_gnt <= LAST_GNT_RST;
        else if (gnt != GNT_NONE)
            last_gnt <= gnt;
    end

    assign pick = (last_gnt == GNT_WR) ? GNT_RD : GNT_WR;
`else
    assign pick = GNT_WR;
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (wr_full && rd_elig)
            gnt = pick;
        else if (wr_full)
            gnt = GNT_WR;
        else if (rd_elig)
            gnt = GNT_RD;
    end

    assign o_Mem_Wr_En   = gnt == GNT_WR;
    assign o_Mem_Addr    = (gnt == GNT_WR) ? wr_pl[AW+WIDTH-1:WIDTH] : (gnt == GNT_RD) ? rd_pl : '0;
    assign o_Mem_Wr_Data = (gnt == GNT_WR) ? wr_pl[WIDTH-1:0] : '0;

    // refill on a read grant takes precedence over the drain
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (gnt == GNT_RD) begin
            rsp_valid <= 1'b1;
            rsp_data  <= i_Mem_Rd_Data;
        end else if (i_Rsp_Ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign o_Rsp_Valid = rsp_valid;
    assign o_Rsp_Data  = rsp_data;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// tb_ram_sp_arbiter: directed table, corner-case sequences and randomized traffic against a behavioural RAM/reference.
module tb_ram_sp_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam int EXP_RD_CYC = 1;
`else
    localparam int EXP_RD_CYC = 8;
`endif

    logic        i_Clk;
    logic        i_Rst_L;
    logic        i_Wr_Valid;
    logic        o_Wr_Ready;
    logic [7:0]  i_Wr_Addr;
    logic [15:0] i_Wr_Data;
    logic        i_Rd_Valid;
    logic        o_Rd_Ready;
    logic [7:0]  i_Rd_Addr;
    logic        o_Rsp_Valid;
    logic        i_Rsp_Ready;
    logic [15:0] o_Rsp_Data;
    logic        o_Mem_Wr_En;
    logic [7:0]  o_Mem_Addr;
    logic [15:0] o_Mem_Wr_Data;
    logic [15:0] i_Mem_Rd_Data;

    logic [15:0] mem [256];
    logic [15:0] refm [256];
    int n_chk = 0;
    int n_fail = 0;

    ram_sp_arbiter #(.WIDTH(16), .DEPTH(256)) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_Wr_Valid    (i_Wr_Valid),
        .o_Wr_Ready    (o_Wr_Ready),
        .i_Wr_Addr     (i_Wr_Addr),
        .i_Wr_Data     (i_Wr_Data),
        .i_Rd_Valid    (i_Rd_Valid),
        .o_Rd_Ready    (o_Rd_Ready),
        .i_Rd_Addr     (i_Rd_Addr),
        .o_Rsp_Valid   (o_Rsp_Valid),
        .i_Rsp_Ready   (i_Rsp_Ready),
        .o_Rsp_Data    (o_Rsp_Data),
        .o_Mem_Wr_En   (o_Mem_Wr_En),
        .o_Mem_Addr    (o_Mem_Addr),
        .o_Mem_Wr_Data (o_Mem_Wr_Data),
        .i_Mem_Rd_Data (i_Mem_Rd_Data)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // behavioural single-port RAM: combinational read, write on the edge
    assign i_Mem_Rd_Data = mem[o_Mem_Addr];
    always @(posedge i_Clk) if (o_Mem_Wr_En) mem[o_Mem_Addr] <= o_Mem_Wr_Data;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wr_op(input logic [7:0] a, input logic [15:0] d);
        logic ok;
        ok = 1'b0;
        i_Wr_Valid = 1'b1;
        i_Wr_Addr  = a;
        i_Wr_Data  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge i_Clk);
            ok = o_Wr_Ready;
            tick();
        end
        i_Wr_Valid = 1'b0;
        chk("wr_accept", ok, 1);
        @(negedge i_Clk);
        chk("wr_mem_en", o_Mem_Wr_En, 1);
        chk("wr_mem_addr", o_Mem_Addr, a);
        chk("wr_mem_data", o_Mem_Wr_Data, d);
        tick();
    endtask

    task automatic rd_op(input logic [7:0] a, input logic [15:0] exp);
        logic ok;
        logic got;
        int lat;
        ok = 1'b0;
        got = 1'b0;
        lat = 0;
        i_Rsp_Ready = 1'b1;
        i_Rd_Valid = 1'b1;
        i_Rd_Addr  = a;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge i_Clk);
            ok = o_Rd_Ready;
            tick();
        end
        i_Rd_Valid = 1'b0;
        chk("rd_accept", ok, 1);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge i_Clk);
            if (o_Rsp_Valid) begin
                got = 1'b1;
                chk("rd_data", o_Rsp_Data, exp);
            end else begin
                tick();
                lat++;
            end
        end
        chk("rd_latency", lat, 1);
        tick();
        @(negedge i_Clk);
        chk("rsp_drained", o_Rsp_Valid, 0);
        tick();
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } vec_t;

    initial begin
        vec_t tbl [8];
        logic r;
        logic [15:0] got_q [$];
        logic [15:0] exp_q [$];
        int wi, ri, nr, rd_cyc, errs, gaps, last, held_bad;
        logic rsp_got, held, wr_seen, rsp_seen;
        logic [15:0] held_d, last_d;

        tbl[0] = '{1'b1, 8'h10, 16'hBEEF};
        tbl[1] = '{1'b0, 8'h10, 16'hBEEF};
        tbl[2] = '{1'b1, 8'h00, 16'h1234};
        tbl[3] = '{1'b1, 8'hFF, 16'hABCD};
        tbl[4] = '{1'b0, 8'h00, 16'h1234};
        tbl[5] = '{1'b0, 8'hFF, 16'hABCD};
        tbl[6] = '{1'b1, 8'h10, 16'h5555};
        tbl[7] = '{1'b0, 8'h10, 16'h5555};

        i_Rst_L = 1'b0;
        i_Wr_Valid = 1'b0;
        i_Wr_Addr = '0;
        i_Wr_Data = '0;
        i_Rd_Valid = 1'b0;
        i_Rd_Addr = '0;
        i_Rsp_Ready = 1'b1;

        // reset state
        repeat (2) @(negedge i_Clk);
        chk("rst_wr_ready", o_Wr_Ready, 0);
        chk("rst_rd_ready", o_Rd_Ready, 0);
        chk("rst_rsp_valid", o_Rsp_Valid, 0);
        chk("rst_rsp_data", o_Rsp_Data, 0);
        chk("rst_mem_wr_en", o_Mem_Wr_En, 0);
        chk("rst_mem_addr", o_Mem_Addr, 0);
        chk("rst_mem_wr_data", o_Mem_Wr_Data, 0);
        i_Rst_L = 1'b1;
        tick();
        @(negedge i_Clk);
        chk("idle_wr_ready", o_Wr_Ready, 1);
        chk("idle_rd_ready", o_Rd_Ready, 1);
        chk("idle_mem_addr", o_Mem_Addr, 0);
        tick();

        // directed table
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) wr_op(tbl[i].addr, tbl[i].data);
            else rd_op(tbl[i].addr, tbl[i].data);
        end

        // write and read of 0x20 presented together: write goes first, read sees new data
        i_Wr_Valid = 1'b1;
        i_Wr_Addr = 8'h20;
        i_Wr_Data = 16'hC0DE;
        i_Rd_Valid = 1'b1;
        i_Rd_Addr = 8'h20;
        tick();
        i_Wr_Valid = 1'b0;
        i_Rd_Valid = 1'b0;
        @(negedge i_Clk);
        chk("same_c0_wr_en", o_Mem_Wr_En, 1);
        chk("same_c0_addr", o_Mem_Addr, 8'h20);
        tick();
        @(negedge i_Clk);
        chk("same_c1_wr_en", o_Mem_Wr_En, 0);
        chk("same_c1_addr", o_Mem_Addr, 8'h20);
        tick();
        @(negedge i_Clk);
        chk("same_rsp_valid", o_Rsp_Valid, 1);
        chk("same_rsp_data", o_Rsp_Data, 16'hC0DE);
        repeat (2) tick();

        // continuous writes with one competing read
        wi = 0;
        rd_cyc = -1;
        rsp_got = 1'b0;
        i_Wr_Valid = 1'b1;
        i_Wr_Addr = 8'h40;
        i_Wr_Data = 16'hA000;
        i_Rd_Valid = 1'b1;
        i_Rd_Addr = 8'h10;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_Clk);
            r = o_Wr_Ready;
            if (rd_cyc < 0 && !o_Mem_Wr_En && o_Mem_Addr == 8'h10) rd_cyc = c - 1;
            if (o_Rsp_Valid && !rsp_got) begin
                rsp_got = 1'b1;
                chk("cont_rd_data", o_Rsp_Data, 16'h5555);
            end
            tick();
            i_Rd_Valid = 1'b0;
            if (i_Wr_Valid && r) begin
                wi++;
                if (wi == 8) i_Wr_Valid = 1'b0;
                else begin
                    i_Wr_Addr = 8'(8'h40 + wi);
                    i_Wr_Data = 16'(16'hA000 + wi);
                end
            end
        end
        chk("cont_rd_cycle", rd_cyc, EXP_RD_CYC);
        chk("cont_rsp_seen", rsp_got, 1);
        chk("cont_writes", wi, 8);
        for (int i = 0; i < 8; i++) chk("cont_wr_mem", mem[8'h40 + i], 16'(16'hA000 + i));

        // response back-pressure with three reads queued
        i_Rsp_Ready = 1'b0;
        ri = 0;
        held_bad = 0;
        i_Rd_Valid = 1'b1;
        i_Rd_Addr = 8'h40;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_Clk);
            r = o_Rd_Ready;
            if (c == 6) begin
                chk("bp_rd_ready", o_Rd_Ready, 0);
                chk("bp_rsp_valid", o_Rsp_Valid, 1);
                chk("bp_hold_data", o_Rsp_Data, 16'hA000);
            end
            if (o_Rsp_Valid && i_Rsp_Ready) got_q.push_back(o_Rsp_Data);
            if (o_Rsp_Valid && !i_Rsp_Ready && o_Rsp_Data !== 16'hA000) held_bad++;
            tick();
            if (i_Rd_Valid && r) begin
                ri++;
                if (ri == 3) i_Rd_Valid = 1'b0;
                else i_Rd_Addr = 8'(8'h40 + ri);
            end
            if (c == 7) i_Rsp_Ready = 1'b1;
        end
        chk("bp_stable", held_bad, 0);
        chk("bp_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got_q.size()) chk("bp_order", got_q[i], 16'(16'hA000 + i));

        // preload RAM and reference for a full sweep
        for (int i = 0; i < 256; i++) begin
            mem[i] <= 16'(i * 257) ^ 16'h5A5A;
            refm[i] = 16'(i * 257) ^ 16'h5A5A;
        end
        tick();

        // back-to-back reads 0x00..0xFF
        ri = 0;
        nr = 0;
        errs = 0;
        gaps = 0;
        last = -1;
        last_d = '0;
        i_Rsp_Ready = 1'b1;
        i_Rd_Valid = 1'b1;
        i_Rd_Addr = 8'h00;
        for (int c = 0; c < 300 && nr < 256; c++) begin
            @(negedge i_Clk);
            r = o_Rd_Ready;
            if (o_Rsp_Valid) begin
                if (o_Rsp_Data !== refm[nr]) errs++;
                if (last >= 0 && c != last + 1) gaps++;
                last = c;
                last_d = o_Rsp_Data;
                nr++;
            end
            tick();
            if (i_Rd_Valid && r) begin
                ri++;
                if (ri == 256) i_Rd_Valid = 1'b0;
                else i_Rd_Addr = 8'(ri);
            end
        end
        chk("b2b_count", nr, 256);
        chk("b2b_data_errs", errs, 0);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_last_ff", last_d, refm[255]);
        repeat (2) tick();

        // randomized traffic: write bursts then read bursts with random response stalls
        for (int round = 0; round < 6; round++) begin
            nr = $urandom_range(1, 12);
            wi = 0;
            for (int c = 0; c < 200 && wi < nr; c++) begin
                @(negedge i_Clk);
                r = o_Wr_Ready;
                tick();
                if (i_Wr_Valid && r) begin
                    refm[i_Wr_Addr] = i_Wr_Data;
                    wi++;
                    i_Wr_Valid = 1'b0;
                end
                if (!i_Wr_Valid && wi < nr && $urandom_range(0, 3) != 0) begin
                    i_Wr_Valid = 1'b1;
                    i_Wr_Addr = 8'($urandom);
                    i_Wr_Data = 16'($urandom);
                end
            end
            chk("rand_wr_done", wi, nr);
            i_Wr_Valid = 1'b0;
            repeat (3) tick();
            nr = $urandom_range(1, 12);
            ri = 0;
            held = 1'b0;
            held_d = '0;
            held_bad = 0;
            exp_q.delete();
            for (int c = 0; c < 300 && (ri < nr || exp_q.size() > 0); c++) begin
                @(negedge i_Clk);
                r = o_Rd_Ready;
                if (o_Rsp_Valid && i_Rsp_Ready) begin
                    if (exp_q.size() == 0) chk("rand_rd_extra", 1, 0);
                    else chk("rand_rd_data", o_Rsp_Data, exp_q.pop_front());
                end
                if (held && o_Rsp_Data !== held_d) held_bad++;
                held = o_Rsp_Valid && !i_Rsp_Ready;
                held_d = o_Rsp_Data;
                tick();
                if (i_Rd_Valid && r) begin
                    exp_q.push_back(refm[i_Rd_Addr]);
                    ri++;
                    i_Rd_Valid = 1'b0;
                end
                if (!i_Rd_Valid && ri < nr && $urandom_range(0, 3) != 0) begin
                    i_Rd_Valid = 1'b1;
                    i_Rd_Addr = 8'($urandom);
                end
                i_Rsp_Ready = $urandom_range(0, 2) != 0;
            end
            chk("rand_rd_done", ri, nr);
            chk("rand_rd_pending", exp_q.size(), 0);
            chk("rand_rsp_stable", held_bad, 0);
            i_Rd_Valid = 1'b0;
            i_Rsp_Ready = 1'b1;
            repeat (3) tick();
        end

        // reset with a held response, a full read slot and a write being offered
        i_Rsp_Ready = 1'b0;
        i_Rd_Valid = 1'b1;
        i_Rd_Addr = 8'h05;
        tick();
        i_Rd_Addr = 8'h06;
        tick();
        i_Rd_Valid = 1'b0;
        @(negedge i_Clk);
        chk("rst_pre_rsp_valid", o_Rsp_Valid, 1);
        chk("rst_pre_rd_ready", o_Rd_Ready, 0);
        #1;
        i_Wr_Valid = 1'b1;
        i_Wr_Addr = 8'h33;
        i_Wr_Data = 16'h7777;
        i_Rst_L = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", o_Rsp_Valid, 0);
        chk("rst_mid_rsp_data", o_Rsp_Data, 0);
        chk("rst_mid_wr_ready", o_Wr_Ready, 0);
        chk("rst_mid_rd_ready", o_Rd_Ready, 0);
        chk("rst_mid_mem_wr_en", o_Mem_Wr_En, 0);
        chk("rst_mid_mem_addr", o_Mem_Addr, 0);
        chk("rst_mid_mem_wr_data", o_Mem_Wr_Data, 0);
        wr_seen = 1'b0;
        rsp_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (o_Mem_Wr_En) wr_seen = 1'b1;
        end
        i_Wr_Valid = 1'b0;
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        i_Rsp_Ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_Clk);
            if (o_Mem_Wr_En) wr_seen = 1'b1;
            if (o_Rsp_Valid) rsp_seen = 1'b1;
        end
        chk("rst_no_write", wr_seen, 0);
        chk("rst_no_rsp", rsp_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
